// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: packed read ports, the single write port and
// the scoreboard reservation port.
interface regfile_mp_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_READ   = 2
);
   logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr;
   logic [NUM_READ*DATA_WIDTH-1:0] rd_data;
   logic [NUM_READ-1:0]            rd_busy;
   logic                           wr_en;
   logic                           wr_link;
   logic [ADDR_WIDTH-1:0]          wr_addr;
   logic [DATA_WIDTH-1:0]          wr_data;
   logic                           rsv_en;
   logic [ADDR_WIDTH-1:0]          rsv_addr;
   logic                           busy_any;

   modport master (
      output rd_addr, wr_en, wr_link, wr_addr, wr_data, rsv_en, rsv_addr,
      input  rd_data, rd_busy, busy_any
   );

   modport slave (
      input  rd_addr, wr_en, wr_link, wr_addr, wr_data, rsv_en, rsv_addr,
      output rd_data, rd_busy, busy_any
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port MIPS register file: async reads, one sync write, link redirect,
// optional zero register and pending-write scoreboard. Macro REGFILE_BYPASS_EN
// enables same-cycle write-through forwarding on the read ports.
module regfile_mp #(
   parameter int          DATA_WIDTH = 32,
   parameter int          ADDR_WIDTH = 5,
   parameter int          NUM_READ   = 2,
   parameter int          ZERO_REG   = 1,
   parameter int          SP_INDEX   = 29,
   parameter logic [31:0] SP_RESET   = 32'h80120002,
   parameter int          RA_INDEX   = 31,
   parameter logic [31:0] RA_RESET   = 32'h77777777
) (
   input  logic         clock,
   input  logic         reset_n,
   regfile_mp_if.slave  bus
);
   localparam int                    DEPTH  = 2**ADDR_WIDTH;
   localparam bit                    ZR     = (ZERO_REG != 0);
   localparam int unsigned           SP_U   = SP_INDEX;
   localparam int unsigned           RA_U   = RA_INDEX;
   localparam logic [ADDR_WIDTH-1:0] RA_IDX = ADDR_WIDTH'(RA_INDEX);

   logic [DATA_WIDTH-1:0] r_regs [DEPTH];
   logic [DEPTH-1:0]      r_busy;
   logic [DEPTH-1:0]      w_busy_nxt;
   logic [ADDR_WIDTH-1:0] w_we_idx;
   logic                  w_we_zero;
   logic                  w_wr_commit;

   assign w_we_idx    = bus.wr_link ? RA_IDX : bus.wr_addr;
   assign w_we_zero   = ZR && (w_we_idx == '0);
   assign w_wr_commit = bus.wr_en && !w_we_zero;

   // Reservation is applied after the write clear so a same-cycle set wins.
   always_comb begin
      w_busy_nxt = r_busy;
      if (bus.wr_en)  w_busy_nxt[w_we_idx]     = 1'b0;
      if (bus.rsv_en) w_busy_nxt[bus.rsv_addr] = 1'b1;
      if (ZR)         w_busy_nxt[0]            = 1'b0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i == SP_U)
               r_regs[i] <= DATA_WIDTH'(SP_RESET);
            else if (i == RA_U)
               r_regs[i] <= DATA_WIDTH'(RA_RESET);
            else
               r_regs[i] <= '0;
         end
         r_busy <= '0;
      end else begin
         if (w_wr_commit) r_regs[w_we_idx] <= bus.wr_data;
         r_busy <= w_busy_nxt;
      end
   end

   for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
      logic [ADDR_WIDTH-1:0] w_ra;
      logic [DATA_WIDTH-1:0] w_rdata;
      logic                  w_rbusy;

      assign w_ra = bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

      always_comb begin
         w_rdata = (ZR && (w_ra == '0)) ? '0 : r_regs[w_ra];
         w_rbusy = r_busy[w_ra];
`ifdef REGFILE_BYPASS_EN
         // A same-cycle reservation of the written index is a new producer.
         if (w_wr_commit && (w_ra == w_we_idx)) begin
            w_rdata = bus.wr_data;
            if (!(bus.rsv_en && (bus.rsv_addr == w_we_idx))) w_rbusy = 1'b0;
         end
`endif
      end

      assign bus.rd_data[p*DATA_WIDTH +: DATA_WIDTH] = w_rdata;
      assign bus.rd_busy[p]                          = w_rbusy;
   end

   assign bus.busy_any = |r_busy;
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized
// traffic against an array-based reference model.
module tb_regfile_mp;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;

   logic clock   = 1'b0;
   logic reset_n = 1'b1;
   always #5 clock = ~clock;

   regfile_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) bus ();

   regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int unsigned vectors = 0;
   int unsigned errors  = 0;

   logic [DW-1:0] m_reg  [32];
   logic          m_busy [32];

   task automatic m_reset();
      for (int i = 0; i < 32; i++) begin
         m_reg[i]  = (i == 29) ? 32'h80120002 : (i == 31) ? 32'h77777777 : 32'h0;
         m_busy[i] = 1'b0;
      end
   endtask

   function automatic int widx();
      return bus.wr_link ? 31 : int'(bus.wr_addr);
   endfunction

   task automatic m_commit();
      int w;
      w = widx();
      if (bus.wr_en) begin
         if (w != 0) m_reg[w] = bus.wr_data;
         m_busy[w] = 1'b0;
      end
      if (bus.rsv_en && bus.rsv_addr != 0) m_busy[bus.rsv_addr] = 1'b1;
   endtask

   function automatic logic [DW-1:0] exp_data(int a);
      if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (bus.wr_en && a == widx()) return bus.wr_data;
`endif
      return m_reg[a];
   endfunction

   function automatic logic exp_busy(int a);
`ifdef REGFILE_BYPASS_EN
      if (bus.wr_en && a == widx() && !(bus.rsv_en && int'(bus.rsv_addr) == widx()))
         return 1'b0;
`endif
      return m_busy[a];
   endfunction

   function automatic logic exp_any();
      logic r;
      r = 1'b0;
      for (int i = 0; i < 32; i++) r |= m_busy[i];
      return r;
   endfunction

   function automatic logic [DW-1:0] rdat(int p);
      return bus.rd_data[p*DW +: DW];
   endfunction

   task automatic set_rd(int p, int a);
      bus.rd_addr[p*AW +: AW] = AW'(a);
   endtask

   task automatic idle();
      bus.wr_en = 1'b0; bus.wr_link = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.rsv_en = 1'b0; bus.rsv_addr = '0;
   endtask

   // Advance one clock: model commits with the inputs present at the edge.
   task automatic cycle();
      @(posedge clock);
      if (reset_n) m_commit();
      #1;
   endtask

   task automatic test_reset();
      idle();
      bus.rd_addr = '0;
      #2 reset_n = 1'b0;
      m_reset();
      set_rd(0, 29); set_rd(1, 31);
      #1;
      vectors++;
      if (rdat(0) !== 32'h80120002) begin errors++; $display("FAIL reset_hold_sp got %h want %h", rdat(0), 32'h80120002); end
      @(negedge clock) reset_n = 1'b1;
      #1;
      vectors++;
      if (rdat(1) !== 32'h77777777) begin errors++; $display("FAIL reset_ra got %h want %h", rdat(1), 32'h77777777); end
      set_rd(0, 5);
      #1;
      vectors++;
      if (rdat(0) !== 32'h0) begin errors++; $display("FAIL reset_r5 got %h want 0", rdat(0)); end
      vectors++;
      if (bus.rd_busy !== 2'b00 || bus.busy_any !== 1'b0) begin
         errors++; $display("FAIL reset_busy got %b/%b want 00/0", bus.rd_busy, bus.busy_any);
      end
      cycle();
   endtask

   task automatic test_write_read();
      logic [DW-1:0] want;
      bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'hDEADBEEF;
      set_rd(0, 7); set_rd(1, 7);
`ifdef REGFILE_BYPASS_EN
      want = 32'hDEADBEEF;
`else
      want = 32'h0;
`endif
      #1;
      vectors++;
      if (rdat(0) !== want) begin errors++; $display("FAIL wr_same_cycle got %h want %h", rdat(0), want); end
      cycle();
      idle();
      #1;
      for (int p = 0; p < NR; p++) begin
         vectors++;
         if (rdat(p) !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_next port%0d got %h want deadbeef", p, rdat(p)); end
      end
   endtask

   task automatic test_zero();
      bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'h12345678;
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd0;
      set_rd(0, 0); set_rd(1, 0);
      #1;
      vectors++;
      if (rdat(0) !== 32'h0) begin errors++; $display("FAIL zero_same got %h want 0", rdat(0)); end
      cycle();
      idle();
      #1;
      vectors++;
      if (rdat(1) !== 32'h0) begin errors++; $display("FAIL zero_after got %h want 0", rdat(1)); end
      vectors++;
      if (bus.rd_busy !== 2'b00 || bus.busy_any !== 1'b0) begin
         errors++; $display("FAIL zero_busy got %b/%b want 00/0", bus.rd_busy, bus.busy_any);
      end
   endtask

   task automatic test_link();
      bus.wr_en = 1'b1; bus.wr_link = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h00400010;
      cycle();
      idle();
      set_rd(0, 31); set_rd(1, 3);
      #1;
      vectors++;
      if (rdat(0) !== 32'h00400010) begin errors++; $display("FAIL link_ra got %h want 00400010", rdat(0)); end
      vectors++;
      if (rdat(1) !== 32'h0) begin errors++; $display("FAIL link_r3 got %h want 0", rdat(1)); end
   endtask

   task automatic test_scoreboard();
      set_rd(0, 9); set_rd(1, 8);
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd9;
      cycle();
      idle();
      #1;
      vectors++;
      if (bus.rd_busy !== 2'b01 || bus.busy_any !== 1'b1) begin
         errors++; $display("FAIL sb_reserve got %b/%b want 01/1", bus.rd_busy, bus.busy_any);
      end
      bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h99;
      cycle();
      idle();
      #1;
      vectors++;
      if (bus.rd_busy[0] !== 1'b0 || bus.busy_any !== 1'b0) begin
         errors++; $display("FAIL sb_clear got %b/%b want 0/0", bus.rd_busy[0], bus.busy_any);
      end
      bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h9A;
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd9;
      cycle();
      idle();
      #1;
      vectors++;
      if (bus.rd_busy[0] !== 1'b1 || rdat(0) !== 32'h9A) begin
         errors++; $display("FAIL sb_set_wins got %b/%h want 1/0000009a", bus.rd_busy[0], rdat(0));
      end
      bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 32'h9B;
      cycle();
      idle();
   endtask

   task automatic test_midreset();
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd4;
      cycle();
      bus.rsv_addr = 5'd6;
      cycle();
      idle();
      bus.wr_en = 1'b1; bus.wr_addr = 5'd4; bus.wr_data = 32'hA5A5A5A5;
      set_rd(0, 29); set_rd(1, 6);
      #6 reset_n = 1'b0;
      m_reset();
      #1;
      vectors++;
      if (bus.busy_any !== 1'b0 || rdat(0) !== 32'h80120002) begin
         errors++; $display("FAIL midrst_hold got %b/%h want 0/80120002", bus.busy_any, rdat(0));
      end
      @(posedge clock);
      #3 reset_n = 1'b1;
      idle();
      set_rd(0, 4);
      #1;
      vectors++;
      if (rdat(0) !== 32'h0) begin errors++; $display("FAIL midrst_r4 got %h want 0", rdat(0)); end
      vectors++;
      if (bus.busy_any !== 1'b0 || bus.rd_busy !== 2'b00) begin
         errors++; $display("FAIL midrst_busy got %b/%b want 0/00", bus.busy_any, bus.rd_busy);
      end
   endtask

   task automatic test_random();
      int a;
      for (int n = 0; n < 400; n++) begin
         bus.wr_en    = ($urandom_range(0, 1) == 1);
         bus.wr_link  = ($urandom_range(0, 9) == 0);
         bus.wr_addr  = AW'($urandom_range(0, 11));
         bus.wr_data  = DW'($urandom);
         bus.rsv_en   = ($urandom_range(0, 2) == 0);
         bus.rsv_addr = AW'($urandom_range(0, 11));
         for (int p = 0; p < NR; p++)
            set_rd(p, ($urandom_range(0, 7) == 0) ? 31 : $urandom_range(0, 11));
         #1;
         for (int p = 0; p < NR; p++) begin
            a = int'(bus.rd_addr[p*AW +: AW]);
            vectors++;
            if (rdat(p) !== exp_data(a) || bus.rd_busy[p] !== exp_busy(a)) begin
               errors++;
               $display("FAIL rand_port%0d addr %0d got %h/%b want %h/%b",
                        p, a, rdat(p), bus.rd_busy[p], exp_data(a), exp_busy(a));
            end
         end
         vectors++;
         if (bus.busy_any !== exp_any()) begin
            errors++; $display("FAIL rand_busy_any got %b want %b", bus.busy_any, exp_any());
         end
         cycle();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_zero();
      test_link();
      test_scoreboard();
      test_midreset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port general-purpose register file for the MIPS datapath, the successor to the fixed 32x32 two-read-port file. Reads are asynchronous on any number of ports and writes are synchronous on the rising clock edge. It adds an asynchronous reset to defined architectural values, an optional hardwired zero register, link-register redirection, and a per-register pending-write scoreboard so decode can stall on in-flight loads.

Parameters:
DATA_WIDTH, 32, register width in bits
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
NUM_READ, 2, number of asynchronous read ports (>=1)
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/reservations
SP_INDEX, 29, stack pointer index
SP_RESET, 32'h80120002, stack pointer reset value
RA_INDEX, 31, return-address index
RA_RESET, 32'h77777777, return-address reset value

Ports:
clock  in  1  system clock, rising-edge active
reset_n  in  1  asynchronous active-low reset
rd_addr  in  NUM_READ*ADDR_WIDTH  read indices; port p occupies bits [p*ADDR_WIDTH +: ADDR_WIDTH]
rd_data  out  NUM_READ*DATA_WIDTH  read data, same packing
rd_busy  out  NUM_READ  1 = indexed register has a pending write
wr_en  in  1  write enable
wr_link  in  1  when wr_en=1, redirect the write to RA_INDEX and ignore wr_addr
wr_addr  in  ADDR_WIDTH  write index
wr_data  in  DATA_WIDTH  write data
rsv_en  in  1  reserve a register (mark its write pending)
rsv_addr  in  ADDR_WIDTH  index to reserve
busy_any  out  1  OR of all scoreboard bits

Behaviour:
- Clock is one domain named clock. Reset is reset_n: asynchronous assert, active-low. Deassertion is synchronised externally.
- Reset state:
  - All registers are 0, except reg[SP_INDEX]=SP_RESET and reg[RA_INDEX]=RA_RESET.
  - All scoreboard bits are 0.
  - rd_busy is therefore 0 and busy_any is 0.
  - While reset is held, rd_data shows the reset contents.
- Reset mid-operation: asserting reset_n=0 immediately discards every pending write and reservation. No write is committed on an edge while reset_n=0.
- Effective write index: we_idx = wr_link ? RA_INDEX : wr_addr.
- Write: on the rising edge with wr_en=1, reg[we_idx] <= wr_data.
  - If ZERO_REG=1 and we_idx=0, the write is dropped.
- Read: rd_data[p] = reg[rd_addr[p]], combinational, with zero latency from the address.
  - If ZERO_REG=1, index 0 always reads 0.
  - Without bypass, a read and a write to the same index in the same cycle return the old value. The new value is visible the cycle after the edge.
- Scoreboard, one bit per register. Updates are applied at the rising edge.
  - wr_en=1 clears busy[we_idx].
  - rsv_en=1 sets busy[rsv_addr].
  - Reservation and write to the same index in the same cycle: the set wins, so busy stays 1. This is a new in-flight producer.
  - Reserving an already-busy register leaves it at 1. A write to a non-busy register leaves it at 0.
  - ZERO_REG=1: reservations of index 0 are ignored and busy[0] is always 0.
- rd_busy[p] = busy[rd_addr[p]], combinational.
- busy_any = |busy, combinational.
- Multiple read ports may address the same index and all return identical data.
- There is exactly one write port, so no write-write conflicts exist.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined:
  - Write-through forwarding. When wr_en=1 and rd_addr[p]==we_idx (and the index is not the hardwired zero), rd_data[p]=wr_data in the same cycle.
  - rd_busy[p] is forced to 0 for that port in that cycle, unless rsv_en=1 with rsv_addr==we_idx.
- Not defined: reads return stored contents only, and rd_busy reflects the stored scoreboard bits only.
- The register array and scoreboard update rules are identical in both builds.

Test Plan:
- Reset: drive reset_n=0 mid-cycle, then release. Required: port 0 reads addr 29 -> 32'h80120002, addr 31 -> 32'h77777777, addr 5 -> 0. rd_busy=0 and busy_any=0.
- Write/read: write 32'hDEADBEEF to reg 7. Required: the same-cycle read of 7 returns the old value 0 without bypass and 32'hDEADBEEF with bypass; the next cycle all ports read 32'hDEADBEEF.
- Zero register: with ZERO_REG=1, write 32'h12345678 to reg 0 and reserve reg 0. Required: reads of 0 return 0, rd_busy=0, busy_any=0.
- Link write: set wr_link=1 with wr_addr=3 and wr_data=32'h00400010. Required: reg 31 becomes 32'h00400010 and reg 3 is unchanged.
- Scoreboard:
  - Reserve reg 9 -> rd_busy=1 on the next cycle.
  - Write reg 9 -> busy clears after that edge.
  - Reserve and write reg 9 in the same cycle -> stays busy.
- Mid-operation reset: reserve regs 4 and 6, write reg 4 = 32'hA5A5A5A5, then pulse reset_n low for less than one cycle. Required: busy_any=0, reg 4 = 0, no write committed while reset is low.
